staggered_cla_adder: RTL and testbench

Pipelined wide adder/subtractor built from BLK-bit carry-lookahead slices, one slice per pipeline stage (carry-staggered). Each stage resolves one slice of the sum and registers its carry for the next stage. It is the parametrised successor of the 4-bit combinational CLA and adds valid/ready flow control, subtract mode and signed overflow. It sits in datapaths that need full-throughput WIDTH-bit add at high clock rate.

---
 rtl/adder_pkg.sv | 18 +
 rtl/cla_block.sv | 43 ++++
 rtl/staggered_cla_adder.sv | 103 ++++++++++
 tb/tb_staggered_cla_adder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: default sizing and per-stage pipeline record for the staggered CLA adder
package adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLK   = 4;

    // Per-stage record at the default width. The top declares the same shape
    // at its own WIDTH, so parameter overrides keep the same layout.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 ovf;
        logic [DEF_WIDTH-1:0] a_rem;
        logic [DEF_WIDTH-1:0] b_rem;
        logic [DEF_WIDTH-1:0] sum_done;
    } stage_t;

endpackage

// File: rtl/cla_block.sv
// cla_block: combinational BLK-bit carry-lookahead slice with carry-out and carry into the MSB
module cla_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] x,
    input  logic [BLK-1:0] y,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co,
    output logic           cm
);

    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK:0]   c;

    assign p = x ^ y;
    assign g = x & y;

    // Each carry is a flat sum of generate terms gated by the propagate run above them
    always_comb begin
        logic pp;
        logic cc;
        pp = 1'b1;
        cc = 1'b0;
        c  = '0;
        c[0] = ci;
        for (int i = 0; i < BLK; i++) begin
            cc = 1'b0;
            pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & ci);
        end
    end

    assign s  = p ^ c[BLK-1:0];
    assign co = c[BLK];
    assign cm = c[BLK-1];

endmodule

// File: rtl/staggered_cla_adder.sv
// staggered_cla_adder: pipelined add/sub resolving one BLK-bit CLA slice per stage with valid/ready flow
module staggered_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int STAGES = WIDTH / BLK;

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             ovf;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum_done;
    } rec_t;

    if (BLK < 1 || WIDTH % BLK != 0) begin : g_bad_cfg
        $error("staggered_cla_adder: WIDTH must be a positive multiple of BLK");
    end

    logic advance;
    rec_t head;
    logic unused_rem;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // Subtraction is a + ~b + 1, so operand B is inverted and the carry-in forced
    assign head = '{
        valid:    in_valid,
        carry:    sub ? 1'b1 : ci,
        ovf:      1'b0,
        a_rem:    a,
        b_rem:    sub ? ~b : b,
        sum_done: '0
    };

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        rec_t           src;
        rec_t           nxt;
        rec_t           q;
        logic [BLK-1:0] s;
        logic           c_o;
        logic           c_m;

        if (k == 0) begin : g_first
            assign src = head;
        end else begin : g_next
            assign src = g_st[k-1].q;
        end

        cla_block #(.BLK(BLK)) u_cla (
            .x  (src.a_rem[k*BLK +: BLK]),
            .y  (src.b_rem[k*BLK +: BLK]),
            .ci (src.carry),
            .s  (s),
            .co (c_o),
            .cm (c_m)
        );

        // Resolve this slice and forward its carry; ovf is only meaningful at the last slice
        always_comb begin
            nxt                        = src;
            nxt.carry                  = c_o;
            nxt.ovf                    = c_m ^ c_o;
            nxt.sum_done[k*BLK +: BLK] = s;
        end

        // Data loads only with valid input so the output holds the last result through bubbles
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                q <= '0;
            else if (advance && src.valid)
                q <= nxt;
            else if (advance)
                q.valid <= 1'b0;
        end
    end

    assign out_valid  = g_st[STAGES-1].q.valid;
    assign sum        = g_st[STAGES-1].q.sum_done;
    assign co         = g_st[STAGES-1].q.carry;
    assign ovf        = g_st[STAGES-1].q.ovf;
    assign unused_rem = ^{g_st[STAGES-1].q.a_rem, g_st[STAGES-1].q.b_rem};

endmodule

// File: tb/tb_staggered_cla_adder.sv
// tb_staggered_cla_adder: directed and scoreboarded checks of the pipelined CLA adder
module tb_staggered_cla_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ci = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        co;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];

    staggered_cla_adder #(.WIDTH(32), .BLK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] model(logic [31:0] a_i, logic [31:0] b_i, logic ci_i, logic sub_i);
        logic [31:0] be;
        logic [32:0] r;
        logic        v;
        be = sub_i ? ~b_i : b_i;
        r  = {1'b0, a_i} + {1'b0, be} + {32'd0, sub_i ? 1'b1 : ci_i};
        v  = (a_i[31] == be[31]) && (r[31] != a_i[31]);
        return {v, r[32], r[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: bookkeeping of both handshakes at the negedge, then advance past posedge
    task automatic tick();
        logic [33:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_result", 64'({ovf, co, sum}), 64'(e));
            end
        end
        if (in_valid && in_ready)
            exp_q.push_back(model(a, b, ci, sub));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] a_i, input logic [31:0] b_i,
                            input logic ci_i, input logic sub_i,
                            input logic [31:0] e_sum, input logic e_co, input logic e_ovf);
        int n;
        a = a_i; b = b_i; ci = ci_i; sub = sub_i; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd8);
        chk({tag, "_sum"}, 64'(sum), 64'(e_sum));
        chk({tag, "_co"}, 64'(co), 64'(e_co));
        chk({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
        tick();
    endtask

    task automatic drain(input string tag);
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [33:0] snap;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_co_ovf", 64'({co, ovf}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #4;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors with hand-computed results
        directed("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("add_ci", 32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
        directed("add_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        directed("sub_eq", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

        // Back-to-back random stream at full throughput
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
            chk("b2b_in_ready", 64'(in_ready), 64'd1);
            tick();
            chk("b2b_out_valid", 64'(out_valid), 64'(i >= 7));
        end
        drain("b2b_drain");

        // Fill with the consumer stalled, then hold and verify nothing moves
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
            tick();
        end
        chk("fill_count", 64'(exp_q.size()), 64'd8);
        snap = {ovf, co, sum};
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom;
            tick();
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", 64'({ovf, co, sum}), 64'(snap));
        end
        drain("stall_drain");

        // Random valid/ready toggling
        for (int i = 0; i < 400; i++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        drain("rand_drain");

        // Full pipe, then reset between edges: outputs must clear without a clock edge
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_sum_co_ovf", 64'({ovf, co, sum}), 64'd0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;

        // Only post-reset transactions may emerge
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
            tick();
        end
        drain("post_rst_drain");
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
